// File: rtl/cpu6502_pkg.sv
// Shared cpu6502 definitions: opcodes, bus direction encoding, TCU width and
// the timing-control FSM state encoding.
package cpu6502_pkg;

    localparam int TCU_WIDTH = 4;

    localparam logic [7:0] OP_BRK     = 8'h00;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_JAM   = 2'd2
    } tcu_state_e;

endpackage

// File: rtl/timing_control.sv
// Instruction register and timing-control-unit state for the cpu6502 core:
// reset BRK entry, RDY stalling, jam detection and a retired-fetch counter.
module timing_control
    import cpu6502_pkg::*;
#(
    parameter int MAX_TCU     = 7,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [7:0]             i_data,
    input  logic [TCU_WIDTH-1:0]   i_tcu_next,
    input  logic                   i_rw,
    input  logic                   i_rdy,
    output logic [7:0]             o_ir,
    output logic [TCU_WIDTH-1:0]   o_tcu,
    output logic                   o_sync,
    output logic                   o_rst_seq,
    output logic                   o_jam,
    output logic [COUNT_WIDTH-1:0] o_instr_count
);

    tcu_state_e             state_q, state_d;
    logic [7:0]             ir_q, ir_d;
    logic [TCU_WIDTH-1:0]   tcu_q, tcu_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic jam_req;
    logic stall;
    logic in_t0;

    assign jam_req = i_tcu_next > TCU_WIDTH'(MAX_TCU);
    assign stall   = !i_rdy && (i_rw == RW_READ);
    assign in_t0   = (tcu_q == '0);

    // NOTE: every variable gets its hold value first, so paths that do not
    // assign it cannot infer a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        tcu_d   = tcu_q;
        count_d = count_q;

        if (state_q == ST_JAM) begin
            // Sticky until reset.
        end else if (jam_req) begin
            // A jam request outranks a stall in the same cycle.
            state_d = ST_JAM;
        end else if (!stall) begin
            tcu_d = i_tcu_next;
            if (in_t0) begin
                ir_d    = i_data;
                count_d = count_q + COUNT_WIDTH'(1);
            end
            // The forced BRK has finished once the decoder returns to T0.
            if (state_q == ST_RESET && !in_t0 && i_tcu_next == '0) begin
                state_d = ST_RUN;
            end
        end
    end

    // Reset enters BRK at T1 so the first cycle out of reset skips the fetch.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_RESET;
            ir_q    <= OP_BRK;
            tcu_q   <= TCU_WIDTH'(1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tcu_q   <= tcu_d;
            count_q <= count_d;
        end
    end

    assign o_ir          = ir_q;
    assign o_tcu         = tcu_q;
    assign o_instr_count = count_q;
    assign o_rst_seq     = (state_q == ST_RESET);
    assign o_jam         = (state_q == ST_JAM);
    assign o_sync        = in_t0 && (state_q != ST_JAM);

endmodule

// File: tb/tb_timing_control.sv
// Directed bench for timing_control: a vector table for the main flow plus
// hand-written reset, jam-at-T0 and counter-wrap sequences.
module tb_timing_control;
    import cpu6502_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  data;
    logic [3:0]  tcu_next;
    logic        rw;
    logic        rdy;
    logic [7:0]  ir;
    logic [3:0]  tcu;
    logic        sync;
    logic        rst_seq;
    logic        jam;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timing_control #(.MAX_TCU(7), .COUNT_WIDTH(16)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_data       (data),
        .i_tcu_next   (tcu_next),
        .i_rw         (rw),
        .i_rdy        (rdy),
        .o_ir         (ir),
        .o_tcu        (tcu),
        .o_sync       (sync),
        .o_rst_seq    (rst_seq),
        .o_jam        (jam),
        .o_instr_count(instr_count)
    );

    typedef struct {
        logic        rdy;
        logic        rw;
        logic [3:0]  tn;
        logic [7:0]  data;
        logic [3:0]  e_tcu;
        logic [7:0]  e_ir;
        logic [15:0] e_cnt;
        logic        e_sync;
        logic        e_rst;
        logic        e_jam;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic w, input logic [3:0] tn,
                                input logic [7:0] d, input logic [3:0] et,
                                input logic [7:0] ei, input logic [15:0] ec,
                                input logic es, input logic er, input logic ej);
        vec_t v;
        v.rdy = r;  v.rw = w;  v.tn = tn;  v.data = d;
        v.e_tcu = et;  v.e_ir = ei;  v.e_cnt = ec;
        v.e_sync = es;  v.e_rst = er;  v.e_jam = ej;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] e_tcu,
                                 input logic [7:0] e_ir, input logic [15:0] e_cnt,
                                 input logic e_sync, input logic e_rst, input logic e_jam);
        check({tag, ".tcu"},     32'(tcu),         32'(e_tcu));
        check({tag, ".ir"},      32'(ir),          32'(e_ir));
        check({tag, ".count"},   32'(instr_count), 32'(e_cnt));
        check({tag, ".sync"},    32'(sync),        32'(e_sync));
        check({tag, ".rst_seq"}, 32'(rst_seq),     32'(e_rst));
        check({tag, ".jam"},     32'(jam),         32'(e_jam));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] tn, input logic [7:0] d);
        rdy = r;  rw = w;  tcu_next = tn;  data = d;
    endtask

    // Called 1 time unit after a rising edge; reset asserts well before the
    // next edge, so the checked values can only come from the async path.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_outputs({tag, "_async"}, 4'd1, OP_BRK, 16'd0, 1'b0, 1'b1, 1'b0);
        tick();
        reset_n = 1'b1;
        check_outputs({tag, "_held"}, 4'd1, OP_BRK, 16'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // Compliant decoder for BRK out of reset: T1..T6 then back to T0.
    task automatic walk_brk(input string tag);
        logic [3:0] seq [6];
        seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, RW_READ, seq[i], 8'hFF);
            tick();
            check_outputs($sformatf("%s_brk%0d", tag, i), seq[i], OP_BRK, 16'd0,
                          seq[i] == 4'd0, seq[i] != 4'd0, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b1, RW_READ, 4'd0, 8'h00);
        #2;
        do_reset("por");

        // rdy rw tn  data   tcu ir     cnt sync rst jam
        add(1, 1, 2, 8'h00,  2, 8'h00, 0, 0, 1, 0);
        add(1, 1, 3, 8'h00,  3, 8'h00, 0, 0, 1, 0);
        add(0, 1, 7, 8'h00,  3, 8'h00, 0, 0, 1, 0);   // stall during reset BRK
        add(0, 0, 4, 8'h00,  4, 8'h00, 0, 0, 1, 0);   // write ignores rdy
        add(1, 1, 5, 8'h00,  5, 8'h00, 0, 0, 1, 0);
        add(1, 1, 6, 8'h00,  6, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 8'h00,  0, 8'h00, 0, 1, 0, 0);
        add(1, 1, 1, 8'hA9,  1, 8'hA9, 1, 0, 0, 0);
        add(1, 1, 0, 8'hEA,  0, 8'hA9, 1, 1, 0, 0);
        add(0, 1, 1, 8'h77,  0, 8'hA9, 1, 1, 0, 0);   // stalled T0: no fetch
        add(1, 1, 1, 8'hAD,  1, 8'hAD, 2, 0, 0, 0);
        add(1, 1, 2, 8'h33,  2, 8'hAD, 2, 0, 0, 0);
        add(0, 1, 5, 8'h44,  2, 8'hAD, 2, 0, 0, 0);
        add(0, 1, 5, 8'h45,  2, 8'hAD, 2, 0, 0, 0);
        add(0, 1, 5, 8'h46,  2, 8'hAD, 2, 0, 0, 0);
        add(0, 0, 3, 8'h47,  3, 8'hAD, 2, 0, 0, 0);
        add(1, 1, 4, 8'h00,  4, 8'hAD, 2, 0, 0, 0);
        add(1, 1, 5, 8'h00,  5, 8'hAD, 2, 0, 0, 0);
        add(1, 1, 6, 8'h00,  6, 8'hAD, 2, 0, 0, 0);
        add(1, 1, 7, 8'h00,  7, 8'hAD, 2, 0, 0, 0);
        add(0, 1, 8, 8'h99,  7, 8'hAD, 2, 0, 0, 1);   // stall + jam -> jam
        add(1, 1, 0, 8'h11,  7, 8'hAD, 2, 0, 0, 1);
        add(1, 0, 0, 8'h22,  7, 8'hAD, 2, 0, 0, 1);
        add(1, 1, 0, 8'h33,  7, 8'hAD, 2, 0, 0, 1);
        add(1, 0, 1, 8'h44,  7, 8'hAD, 2, 0, 0, 1);
        add(1, 1, 0, 8'h55,  7, 8'hAD, 2, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].rw, vecs[i].tn, vecs[i].data);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_tcu, vecs[i].e_ir,
                          vecs[i].e_cnt, vecs[i].e_sync, vecs[i].e_rst, vecs[i].e_jam);
        end

        do_reset("jam_exit");

        // Reset mid-instruction: IR=0xAD, TCU=3, count=5.
        walk_brk("mid");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, RW_READ, 4'd0, 8'h10 + 8'(i));
            tick();
        end
        check_outputs("mid_t0run", 4'd0, 8'h13, 16'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, RW_READ, 4'd1, OP_LDA_ABS);
        tick();
        drive(1'b1, RW_READ, 4'd2, 8'h00);
        tick();
        drive(1'b1, RW_READ, 4'd3, 8'h00);
        tick();
        check_outputs("mid_pre", 4'd3, OP_LDA_ABS, 16'd5, 1'b0, 1'b0, 1'b0);
        do_reset("mid");

        // Jam requested during a T0 cycle: no fetch, sync gated off.
        walk_brk("jam0");
        drive(1'b1, RW_READ, 4'd15, 8'h55);
        tick();
        check_outputs("jam0", 4'd0, OP_BRK, 16'd0, 1'b0, 1'b0, 1'b1);
        do_reset("jam0_exit");

        // Counter wrap via back-to-back single-cycle fetches.
        walk_brk("wrap");
        drive(1'b1, RW_READ, 4'd0, OP_NOP);
        for (int i = 0; i < 65535; i++) tick();
        check_outputs("wrap_ffff", 4'd0, OP_NOP, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        tick();
        check_outputs("wrap_0000", 4'd0, OP_NOP, 16'h0000, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
